// File: rtl/fdvit_ds_pkg.sv
// Shared types and defaults for the ifmap loader / bilinear downsample path.
package fdvit_ds_pkg;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_HIN   = 27;

  typedef enum logic {FILL, FULL} ldr_state_t;
  typedef logic [DEF_PIX_W-1:0] pix_t;
endpackage

// File: rtl/fmap_bank.sv
// One HIN x HIN pixel register array: single write port, whole map readable in parallel.
module fmap_bank #(
  parameter int HIN   = 27,
  parameter int PIX_W = 8,
  localparam int CW   = $clog2(HIN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CW-1:0]    wr_row,
  input  logic [CW-1:0]    wr_col,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_map [HIN][HIN]
);
  logic [PIX_W-1:0] mem_q [HIN][HIN];
  logic [PIX_W-1:0] mem_d [HIN][HIN];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_row][wr_col] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < HIN; r++)
        for (int c = 0; c < HIN; c++)
          mem_q[r][c] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_map = mem_q;
endmodule

// File: rtl/ifmap_frame_loader.sv
// Assembles a raster pixel stream into a HIN x HIN ifmap held until frame_ack.
// Build option: DOUBLE_BUF_EN selects two ping-pong banks instead of one.
module ifmap_frame_loader
  import fdvit_ds_pkg::*;
#(
  parameter int HIN   = DEF_HIN,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_last,
  output logic [PIX_W-1:0] ifmap [HIN][HIN],
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             len_err,
  output ldr_state_t       dbg_state
);
  // Handshake: a pixel moves when s_valid & s_ready in the same cycle; s_ready
  // depends only on registered state, never on s_valid.
  localparam int CW = $clog2(HIN);
  localparam logic [CW-1:0] LAST = CW'(HIN - 1);

  ldr_state_t    state_q, state_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  logic [1:0]    full_q, full_d;
  logic          fill_sel_q, fill_sel_d, pres_sel_q, pres_sel_d;
  logic          len_err_q, len_err_d;
  logic          acc, at_last, ack_take;

  assign s_ready     = (state_q == FILL);
  assign frame_valid = full_q[pres_sel_q];
  assign len_err     = len_err_q;
  assign dbg_state   = state_q;

  always_comb begin
    acc        = s_valid & s_ready;
    at_last    = (row_q == LAST) && (col_q == LAST);
    ack_take   = frame_ack & frame_valid;
    row_d      = row_q;
    col_d      = col_q;
    full_d     = full_q;
    fill_sel_d = fill_sel_q;
    pres_sel_d = pres_sel_q;
    len_err_d  = 1'b0;
    if (ack_take) begin
      full_d[pres_sel_q] = 1'b0;
      pres_sel_d         = ~pres_sel_q;
    end
    if (acc) begin
      len_err_d = s_last ^ at_last;
      if (at_last) begin
        row_d              = '0;
        col_d              = '0;
        full_d[fill_sel_q] = 1'b1;
        fill_sel_d         = ~fill_sel_q;
        // Present immediately unless the other bank still holds an unacked frame.
        if (!full_d[~fill_sel_q]) pres_sel_d = fill_sel_q;
      end else if (s_last) begin
        row_d = '0;
        col_d = '0;
      end else if (col_q == LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
`ifndef DOUBLE_BUF_EN
    fill_sel_d = 1'b0;
    pres_sel_d = 1'b0;
`endif
    state_d = full_d[fill_sel_d] ? FULL : FILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      row_q      <= '0;
      col_q      <= '0;
      full_q     <= '0;
      fill_sel_q <= 1'b0;
      pres_sel_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      full_q     <= full_d;
      fill_sel_q <= fill_sel_d;
      pres_sel_q <= pres_sel_d;
      len_err_q  <= len_err_d;
    end
  end

  logic [PIX_W-1:0] map0 [HIN][HIN];

`ifdef DOUBLE_BUF_EN
  logic [PIX_W-1:0] map1 [HIN][HIN];

  fmap_bank #(.HIN(HIN), .PIX_W(PIX_W)) u_bank0 (
    .clk(clk), .rst(rst), .we(acc & ~fill_sel_q), .wr_row(row_q), .wr_col(col_q),
    .wr_data(s_data), .rd_map(map0)
  );
  fmap_bank #(.HIN(HIN), .PIX_W(PIX_W)) u_bank1 (
    .clk(clk), .rst(rst), .we(acc & fill_sel_q), .wr_row(row_q), .wr_col(col_q),
    .wr_data(s_data), .rd_map(map1)
  );

  always_comb begin
    for (int r = 0; r < HIN; r++)
      for (int c = 0; c < HIN; c++)
        ifmap[r][c] = pres_sel_q ? map1[r][c] : map0[r][c];
  end
`else
  fmap_bank #(.HIN(HIN), .PIX_W(PIX_W)) u_bank0 (
    .clk(clk), .rst(rst), .we(acc), .wr_row(row_q), .wr_col(col_q),
    .wr_data(s_data), .rd_map(map0)
  );

  assign ifmap = map0;
`endif
endmodule

// File: tb/tb_ifmap_frame_loader.sv
// Directed/randomized bench for ifmap_frame_loader; honours DOUBLE_BUF_EN when defined.
module tb_ifmap_frame_loader;
  import fdvit_ds_pkg::*;

  localparam int HIN = 27;
  localparam int NPIX = HIN * HIN;
`ifdef DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef logic [7:0] frame_t [NPIX];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic [7:0] ifmap [HIN][HIN];
  logic       frame_valid;
  logic       frame_ack = 1'b0;
  logic       len_err;
  ldr_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference: frames completed but not yet acked, oldest (presented) first.
  frame_t pend_q[$];
  frame_t zf, fa, fb;

  ifmap_frame_loader #(.HIN(HIN), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .ifmap(ifmap), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .len_err(len_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int map_diff(input frame_t f);
    int n = 0;
    for (int r = 0; r < HIN; r++)
      for (int c = 0; c < HIN; c++)
        if (ifmap[r][c] !== f[r*HIN + c]) n++;
    return n;
  endfunction

  task automatic rand_frame(output frame_t f);
    for (int i = 0; i < NPIX; i++) f[i] = 8'($urandom_range(255));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Holds one beat until accepted; returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [7:0] d, input logic last);
    bit ok;
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int t = 0; t < 200; t++) begin
      ok = s_ready;
      step();
      if (ok) begin
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("beat_timeout", 32'd1, 32'd0);
  endtask

  task automatic stream(input frame_t f, input int n, input int last_idx, input int idle_pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < idle_pct) step();
      send_beat(f[i], i == last_idx);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_rdy"}, 32'(s_ready), 32'(pend_q.size() < NB));
    chk({tag, "_fv"}, 32'(frame_valid), 32'(pend_q.size() > 0));
    if (pend_q.size() > 0) chk({tag, "_map"}, 32'(map_diff(pend_q[0])), 32'd0);
  endtask

  task automatic do_ack(input string tag);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    if (pend_q.size() > 0) void'(pend_q.pop_front());
    check_outputs(tag);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) zf[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();
    chk("rst_rdy", 32'(s_ready), 32'd1);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_lenerr", 32'(len_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(FILL));
    chk("rst_map", 32'(map_diff(zf)), 32'd0);

    // Frame of index pixels, no gaps
    for (int i = 0; i < NPIX; i++) fa[i] = 8'(i);
    stream(fa, NPIX - 1, -1, 0);
    chk("a_fv_early", 32'(frame_valid), 32'd0);
    send_beat(fa[NPIX-1], 1'b1);
    pend_q.push_back(fa);
    chk("a_lenerr", 32'(len_err), 32'd0);
    check_outputs("a");
    chk("a_corner", 32'(ifmap[26][26]), 32'h0000_00d8);

    if (NB == 2) begin
      rand_frame(fb);
      stream(fb, NPIX, NPIX - 1, 0);
      pend_q.push_back(fb);
      check_outputs("a2");
    end

    // Hold with s_valid asserted: nothing may be accepted
    begin
      int acc_cnt = 0;
      s_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        s_data = 8'($urandom_range(255));
        if (s_ready) acc_cnt++;
        step();
      end
      s_valid = 1'b0;
      chk("hold_acc", 32'(acc_cnt), 32'd0);
      chk("hold_map", 32'(map_diff(pend_q[0])), 32'd0);
    end
    do_ack("ack1");
    while (pend_q.size() > 0) do_ack("drain1");

    // Ack with nothing presented is ignored
    do_ack("idle_ack");

    // Random frame with idle gaps
    rand_frame(fb);
    stream(fb, NPIX, NPIX - 1, 30);
    pend_q.push_back(fb);
    check_outputs("b");
    do_ack("ack_b");

    // Early s_last at index 100
    rand_frame(fb);
    stream(fb, 101, 100, 0);
    chk("early_lenerr", 32'(len_err), 32'd1);
    step();
    chk("early_lenerr_pulse", 32'(len_err), 32'd0);
    check_outputs("early");
    rand_frame(fb);
    stream(fb, NPIX, NPIX - 1, 10);
    pend_q.push_back(fb);
    chk("c_lenerr", 32'(len_err), 32'd0);
    check_outputs("c");
    do_ack("ack_c");

    // Missing s_last on final beat
    rand_frame(fb);
    stream(fb, NPIX, -1, 0);
    pend_q.push_back(fb);
    chk("miss_lenerr", 32'(len_err), 32'd1);
    check_outputs("miss");
    step();
    chk("miss_lenerr_pulse", 32'(len_err), 32'd0);
    do_ack("ack_miss");

    // Reset asserted after 400 beats
    rand_frame(fb);
    stream(fb, 400, -1, 30);
    #2 rst = 1'b1;
    #1;
    pend_q.delete();
    chk("mid_rst_rdy", 32'(s_ready), 32'd1);
    chk("mid_rst_fv", 32'(frame_valid), 32'd0);
    chk("mid_rst_lenerr", 32'(len_err), 32'd0);
    chk("mid_rst_map", 32'(map_diff(zf)), 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();
    rand_frame(fb);
    stream(fb, NPIX, NPIX - 1, 30);
    pend_q.push_back(fb);
    check_outputs("post_rst");
    do_ack("ack_post_rst");

`ifdef DOUBLE_BUF_EN
    // Back-to-back frames, final beat coincident with frame_ack
    rand_frame(fa);
    stream(fa, NPIX, NPIX - 1, 0);
    pend_q.push_back(fa);
    check_outputs("g");
    rand_frame(fb);
    stream(fb, NPIX - 1, -1, 0);
    chk("h_fv_g", 32'(map_diff(fa)), 32'd0);
    frame_ack = 1'b1;
    send_beat(fb[NPIX-1], 1'b1);
    frame_ack = 1'b0;
    void'(pend_q.pop_front());
    pend_q.push_back(fb);
    check_outputs("coinc");
    rand_frame(fa);
    stream(fa, NPIX, NPIX - 1, 20);
    pend_q.push_back(fa);
    check_outputs("both_full");
    do_ack("ack_h");
    do_ack("ack_i");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
